// File: rtl/weight_loader_wq_weight_mmap_m_axi_fifo_pkg.sv
// rtl/weight_loader_wq_weight_mmap_m_axi_fifo_pkg.sv - shared defaults and helpers for the wq_weight m_axi FIFO
package weight_loader_mmap_pkg;

  localparam int FIFO_DEPTH_DEFAULT     = 63;
  localparam int FIFO_AF_MARGIN_DEFAULT = 4;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/weight_loader_wq_weight_mmap_m_axi_fifo_if.sv
// rtl/weight_loader_wq_weight_mmap_m_axi_fifo_if.sv - writer/reader handshake bundle of the wq_weight FIFO
interface weight_loader_wq_weight_mmap_m_axi_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);
  logic                  if_write;
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_full_n;
  logic                  if_almost_full;
  logic                  if_read;
  logic [DATA_WIDTH-1:0] if_dout;
  logic                  if_empty_n;
  logic [ADDR_WIDTH:0]   if_num_data_valid;

  // Master is the user side (writer and reader); slave is the FIFO.
  modport master (
    output if_write, if_din, if_read,
    input  if_full_n, if_almost_full, if_dout, if_empty_n, if_num_data_valid
  );

  modport slave (
    input  if_write, if_din, if_read,
    output if_full_n, if_almost_full, if_dout, if_empty_n, if_num_data_valid
  );
endinterface

// File: rtl/weight_loader_wq_weight_mmap_m_axi_fifo_srl.sv
// rtl/weight_loader_wq_weight_mmap_m_axi_fifo_srl.sv - shift-register storage with addressed output register
module weight_loader_wq_weight_mmap_m_axi_srl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 63
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] dout
);

  // Entry 0 is the newest word; the controller addresses the oldest one.
  logic [DATA_WIDTH-1:0] mem [DEPTH-1];

  // Shift a new word in at entry 0 on every accepted write.
  always_ff @(posedge clk) begin
    if (clk_en && we) begin
      for (int i = DEPTH - 2; i > 0; i--) mem[i] <= mem[i-1];
      mem[0] <= din;
    end
  end

  // Output register: cleared by reset, otherwise loaded from the addressed entry on read.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout <= '0;
    end else if (clk_en && re) begin
      dout <= mem[raddr];
    end
  end

endmodule

// File: rtl/weight_loader_wq_weight_mmap_m_axi_fifo.sv
// rtl/weight_loader_wq_weight_mmap_m_axi_fifo.sv - ready/valid FIFO controller around the shift-register storage
module weight_loader_wq_weight_mmap_m_axi_fifo
  import weight_loader_mmap_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = FIFO_DEPTH_DEFAULT,
  parameter int AF_MARGIN  = FIFO_AF_MARGIN_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clk_en,
  input  logic flush,
  weight_loader_wq_weight_mmap_m_axi_fifo_if.slave fifo_if
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LEVEL_C = CW'(DEPTH - AF_MARGIN);

  if (DEPTH < 2) begin : g_bad_depth
    $error("DEPTH must be at least 2");
  end
  if (clog2(DEPTH - 1) > ADDR_WIDTH) begin : g_bad_addr_width
    $error("ADDR_WIDTH too small to address DEPTH-1 entries");
  end
  if (AF_MARGIN < 1 || AF_MARGIN > DEPTH) begin : g_bad_af_margin
    $error("AF_MARGIN must lie in 1..DEPTH");
  end

  logic [CW-1:0]         mem_cnt;
  logic                  dout_vld;
  logic [CW-1:0]         occ;
  logic                  full_n;
  logic                  push;
  logic                  pop;
  logic                  refill;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  srl_reset;

  // Flags depend on registered state only, so no input reaches an output combinationally.
  assign occ       = mem_cnt + CW'(dout_vld);
  assign full_n    = (occ < DEPTH_C);
  assign srl_reset = ~reset_n;

  assign fifo_if.if_full_n         = full_n;
  assign fifo_if.if_empty_n        = dout_vld;
  assign fifo_if.if_almost_full    = (occ >= AF_LEVEL_C);
  assign fifo_if.if_num_data_valid = occ;

  // Handshake decode; flush suppresses both sides so nothing is accepted in a flush cycle.
  always_comb begin
    push   = clk_en & ~flush & fifo_if.if_write & full_n;
    pop    = clk_en & ~flush & fifo_if.if_read & dout_vld;
    refill = clk_en & ~flush & (mem_cnt != '0) & (~dout_vld | pop);
    // Oldest entry sits at mem_cnt-1 before this edge's shift, so a same-cycle push is harmless.
    raddr  = mem_cnt[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
  end

  // Occupancy state: memory count plus output-register valid.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_cnt  <= '0;
      dout_vld <= 1'b0;
    end else if (clk_en) begin
      if (flush) begin
        mem_cnt  <= '0;
        dout_vld <= 1'b0;
      end else begin
        mem_cnt  <= mem_cnt + CW'(push) - CW'(refill);
        dout_vld <= refill | (dout_vld & ~pop);
      end
    end
  end

  weight_loader_wq_weight_mmap_m_axi_srl #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_srl (
    .clk    (clk),
    .reset  (srl_reset),
    .clk_en (clk_en),
    .we     (push),
    .din    (fifo_if.if_din),
    .re     (refill),
    .raddr  (raddr),
    .dout   (fifo_if.if_dout)
  );

endmodule

// File: tb/tb_weight_loader_wq_weight_mmap_m_axi_fifo.sv
// tb/tb_weight_loader_wq_weight_mmap_m_axi_fifo.sv - self-checking bench for the wq_weight FIFO controller
module tb_weight_loader_wq_weight_mmap_m_axi_fifo;

  localparam int DW    = 32;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int AFM   = 1;
  localparam int NWORDS = 10000;

  logic clk;
  logic reset_n;
  logic clk_en;
  logic flush;

  int total;
  int bad;

  weight_loader_wq_weight_mmap_m_axi_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifc ();

  weight_loader_wq_weight_mmap_m_axi_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .AF_MARGIN  (AFM)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clk_en  (clk_en),
    .flush   (flush),
    .fifo_if (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: queue of every accepted word, plus whether the head is presented to the reader.
  logic [DW-1:0] mq[$];
  bit            m_shown;
  int            m_popped;

  task automatic model_edge(input bit rst_low, input bit en, input bit fl,
                            input bit wr, input bit rd, input logic [DW-1:0] d);
    int held;
    bit p;
    bit a;
    if (rst_low) begin
      mq.delete();
      m_shown = 0;
    end else if (en) begin
      if (fl) begin
        mq.delete();
        m_shown = 0;
      end else begin
        p    = rd && m_shown;
        a    = wr && (mq.size() < DEPTH);
        held = mq.size();
        if (p) begin
          void'(mq.pop_front());
          held--;
          m_popped++;
        end
        // A word becomes visible only one edge after it is stored.
        m_shown = (held > 0);
        if (a) mq.push_back(d);
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input bit en, input bit fl, input bit wr, input bit rd, input logic [DW-1:0] d);
    clk_en       = en;
    flush        = fl;
    ifc.if_write = wr;
    ifc.if_read  = rd;
    ifc.if_din   = d;
    model_edge(!reset_n, en, fl, wr, rd, d);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_full_n"},  ifc.if_full_n,         64'(mq.size() < DEPTH));
    chk({tag, "_empty_n"}, ifc.if_empty_n,        64'(m_shown));
    chk({tag, "_af"},      ifc.if_almost_full,    64'(mq.size() >= DEPTH - AFM));
    chk({tag, "_num"},     ifc.if_num_data_valid, 64'(mq.size()));
    chk({tag, "_occ_bound"}, 64'(ifc.if_num_data_valid <= DEPTH), 64'(1));
    if (m_shown) chk({tag, "_dout"}, ifc.if_dout, mq[0]);
  endtask

  typedef struct {
    bit            wr;
    bit            rd;
    bit            fl;
    logic [DW-1:0] din;
    bit            full_n;
    bit            empty_n;
    bit            af;
    int            num;
    bit            cd;
    logic [DW-1:0] dout;
  } vec_t;

  vec_t tbl[21];

  initial begin
    int rd_idx;
    int pushed;
    int cycles;
    int n;
    bit wr;
    bit rd;
    bit en;

    total = 0;
    bad = 0;
    m_shown = 0;
    m_popped = 0;

    // wr rd fl din | full_n empty_n af num | check_dout dout
    tbl[0]  = '{1, 0, 0, 32'hA0,   1, 0, 0, 1, 0, 32'h0};
    tbl[1]  = '{1, 0, 0, 32'hA1,   1, 1, 0, 2, 1, 32'hA0};
    tbl[2]  = '{1, 0, 0, 32'hA2,   1, 1, 1, 3, 1, 32'hA0};
    tbl[3]  = '{1, 0, 0, 32'hA3,   0, 1, 1, 4, 1, 32'hA0};
    tbl[4]  = '{1, 0, 0, 32'hB0,   0, 1, 1, 4, 1, 32'hA0};
    tbl[5]  = '{1, 1, 0, 32'hB0,   1, 1, 1, 3, 1, 32'hA1};
    tbl[6]  = '{1, 0, 0, 32'hB0,   0, 1, 1, 4, 1, 32'hA1};
    tbl[7]  = '{0, 1, 0, 32'h0,    1, 1, 1, 3, 1, 32'hA2};
    tbl[8]  = '{0, 1, 0, 32'h0,    1, 1, 0, 2, 1, 32'hA3};
    tbl[9]  = '{0, 1, 0, 32'h0,    1, 1, 0, 1, 1, 32'hB0};
    tbl[10] = '{0, 1, 0, 32'h0,    1, 0, 0, 0, 0, 32'h0};
    tbl[11] = '{1, 0, 0, 32'h1234, 1, 0, 0, 1, 0, 32'h0};
    tbl[12] = '{0, 0, 0, 32'h0,    1, 1, 0, 1, 1, 32'h1234};
    tbl[13] = '{0, 1, 0, 32'h0,    1, 0, 0, 0, 0, 32'h0};
    tbl[14] = '{1, 0, 0, 32'h11,   1, 0, 0, 1, 0, 32'h0};
    tbl[15] = '{1, 0, 0, 32'h22,   1, 1, 0, 2, 1, 32'h11};
    tbl[16] = '{1, 0, 0, 32'h33,   1, 1, 1, 3, 1, 32'h11};
    tbl[17] = '{1, 1, 1, 32'h77,   1, 0, 0, 0, 1, 32'h11};
    tbl[18] = '{1, 0, 0, 32'h55,   1, 0, 0, 1, 1, 32'h11};
    tbl[19] = '{0, 0, 0, 32'h0,    1, 1, 0, 1, 1, 32'h55};
    tbl[20] = '{0, 1, 0, 32'h0,    1, 0, 0, 0, 0, 32'h0};

    reset_n = 1'b0;
    cyc(1, 0, 0, 0, '0);
    cyc(1, 0, 0, 0, '0);
    reset_n = 1'b1;
    chk("rst_full_n",  ifc.if_full_n, 1);
    chk("rst_empty_n", ifc.if_empty_n, 0);
    chk("rst_af",      ifc.if_almost_full, 0);
    chk("rst_num",     ifc.if_num_data_valid, 0);
    chk("rst_dout",    ifc.if_dout, 0);

    for (int i = 0; i < 21; i++) begin
      cyc(1, tbl[i].fl, tbl[i].wr, tbl[i].rd, tbl[i].din);
      chk($sformatf("vec%0d_full_n", i),  ifc.if_full_n, 64'(tbl[i].full_n));
      chk($sformatf("vec%0d_empty_n", i), ifc.if_empty_n, 64'(tbl[i].empty_n));
      chk($sformatf("vec%0d_af", i),      ifc.if_almost_full, 64'(tbl[i].af));
      chk($sformatf("vec%0d_num", i),     ifc.if_num_data_valid, 64'(tbl[i].num));
      if (tbl[i].cd) chk($sformatf("vec%0d_dout", i), ifc.if_dout, tbl[i].dout);
    end

    // Reset in the middle of a transfer drops everything and clears the output register.
    cyc(1, 0, 1, 0, 32'hC1);
    cyc(1, 0, 1, 0, 32'hC2);
    cyc(1, 0, 1, 0, 32'hC3);
    check_model("pre_rst");
    reset_n = 1'b0;
    cyc(1, 0, 1, 1, 32'hEE);
    reset_n = 1'b1;
    chk("midrst_num",     ifc.if_num_data_valid, 0);
    chk("midrst_empty_n", ifc.if_empty_n, 0);
    chk("midrst_full_n",  ifc.if_full_n, 1);
    chk("midrst_dout",    ifc.if_dout, 0);

    // clk_en low: handshakes held high must not complete.
    cyc(0, 0, 1, 1, 32'hDD);
    chk("hold_num", ifc.if_num_data_valid, 0);
    cyc(1, 0, 1, 0, 32'h66);
    cyc(0, 0, 1, 1, 32'h67);
    cyc(0, 0, 1, 1, 32'h68);
    chk("hold_empty_n", ifc.if_empty_n, 0);
    chk("hold_num2", ifc.if_num_data_valid, 1);
    cyc(1, 0, 0, 0, '0);
    check_model("hold_after");
    cyc(1, 0, 0, 1, '0);
    check_model("hold_drain");

    // Streaming: both sides active every cycle, data is a counter.
    rd_idx = 0;
    for (int i = 0; i < 100; i++) begin
      if (i >= 2) begin
        chk("stream_empty_n", ifc.if_empty_n, 1);
        chk("stream_occ_range", 64'(ifc.if_num_data_valid >= 1 && ifc.if_num_data_valid <= 2), 1);
      end
      if (ifc.if_empty_n) begin
        chk("stream_data", ifc.if_dout, 64'(rd_idx));
        rd_idx++;
      end
      cyc(1, 0, 1, 1, 32'(i));
      check_model("stream");
    end
    chk("stream_count", 64'(rd_idx), 98);
    n = 0;
    while (mq.size() > 0 && n < 10) begin
      cyc(1, 0, 0, 1, '0);
      n++;
    end
    chk("stream_drain", ifc.if_num_data_valid, 0);

    // Random valid/ready/enable toggling against the reference queue.
    pushed = 0;
    cycles = 0;
    m_popped = 0;
    while ((pushed < NWORDS || mq.size() > 0) && cycles < 60000) begin
      en = ($urandom_range(7) != 0);
      wr = (pushed < NWORDS) && ($urandom_range(3) != 0);
      rd = ($urandom_range(3) != 0);
      if (en && wr && mq.size() < DEPTH) begin
        chk("rand_full_n_pre", ifc.if_full_n, 1);
        pushed++;
      end
      cyc(en, 0, wr, rd, $urandom);
      check_model("rand");
      cycles++;
    end
    chk("rand_budget", 64'(cycles < 60000), 1);
    chk("rand_popped", 64'(m_popped), 64'(NWORDS));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
